// File: rtl/fetch_queue.sv
// Instruction buffer between FETCH and decode: in-order circular queue of
// {pc, command} pairs with valid/ready on both sides and a single-cycle flush.
module fetch_queue #(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XPR_LEN-1:0] in_pc,
    input  logic [XPR_LEN-1:0] in_command,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XPR_LEN-1:0] out_pc,
    output logic [XPR_LEN-1:0] out_command,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [XPR_LEN-1:0] pc_mem  [DEPTH];
    logic [XPR_LEN-1:0] cmd_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic push, pop;

    // Handshakes: no pass-through when full, no bypass when empty.
    assign in_ready  = !rst && !flush && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_pc      = out_valid ? pc_mem[rd_ptr_q]  : '0;
    assign out_command = out_valid ? cmd_mem[rd_ptr_q] : '0;
    assign count       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy state; reset outranks flush, both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; push is already suppressed under rst/flush.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= in_pc;
            cmd_mem[wr_ptr_q] <= in_command;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

    localparam int unsigned XPR_LEN = 32;
    localparam int unsigned DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_command, out_pc, out_command;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cmd;
    } ent_t;

    ent_t q[$];
    bit   known = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(.XPR_LEN(XPR_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_command(in_command),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_command(out_command),
        .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs from queue contents, then apply the coming edge.
    always @(negedge clk) begin
        bit          exp_in_ready, exp_out_valid, do_push, do_pop;
        logic [31:0] exp_pc, exp_cmd;
        if (known) begin
            exp_in_ready  = !rst && !flush && (q.size() < DEPTH);
            exp_out_valid = (q.size() != 0) && !flush;
            exp_pc        = exp_out_valid ? q[0].pc  : 32'h0;
            exp_cmd       = exp_out_valid ? q[0].cmd : 32'h0;
            chk("m_in_ready",  32'(in_ready),  32'(exp_in_ready));
            chk("m_out_valid", 32'(out_valid), 32'(exp_out_valid));
            chk("m_out_pc",    out_pc,  exp_pc);
            chk("m_out_cmd",   out_command, exp_cmd);
            chk("m_count",     32'(count), 32'(q.size()));
        end
        if (rst) begin
            q.delete();
            known = 1'b1;
        end else if (known) begin
            if (flush) begin
                q.delete();
            end else begin
                do_push = in_valid && (q.size() < DEPTH);
                do_pop  = out_ready && (q.size() != 0);
                if (do_pop)  void'(q.pop_front());
                if (do_push) q.push_back('{pc: in_pc, cmd: in_command});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit ordy, input bit fl);
        in_valid   = v;
        in_pc      = pc;
        in_command = pc ^ 32'h0000_0013;
        out_ready  = ordy;
        flush      = fl;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_command = '0;
        tick(); tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc",    out_pc, 32'h0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        // Single push, hold, then pop
        in_valid = 1'b1; in_pc = 32'h1000; in_command = 32'h0000_0013; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_pc",    out_pc, 32'h1000);
        chk("single_cmd",   out_command, 32'h0000_0013);
        chk("single_count", 32'(count), 32'd1);
        tick();
        chk("single_hold_pc", out_pc, 32'h1000);
        out_ready = 1'b1; #1;
        tick();
        out_ready = 1'b0; #1;
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);
        chk("single_pop_cmd",   out_command, 32'h0);

        // Fill to DEPTH, reject fifth, pop one, then accept it
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("full_count",    32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("full_reject_count", 32'(count), 32'd4);
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("full_pop_pc",       out_pc, 32'h0);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        tick();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count",    32'(count), 32'd3);
        chk("after_pop_head",     out_pc, 32'h4);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("refill_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_pc, 32'h4 + 32'(4 * i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drained_count", 32'(count), 32'd0);

        // Streaming: one push and one pop per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            if (i > 0) begin
                chk("stream_count", 32'(count), 32'd1);
                chk("stream_pc",    out_pc, 32'h2000 + 32'(4 * (i - 1)));
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_last_pc", out_pc, 32'h2024);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stream_end_count", 32'(count), 32'd0);

        // Flush with three entries and simultaneous push/pop attempts
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10C, 1'b1, 1'b1);
        chk("flush_in_ready",  32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_flush_count",     32'(count), 32'd0);
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        chk("post_flush_in_ready",  32'(in_ready), 32'd1);
        drive(1'b1, 32'h3000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_head", out_pc, 32'h3000);
        chk("post_flush_cnt1", 32'(count), 32'd1);
        tick();

        // Simultaneous push/pop at count=2, then reset mid-operation
        drive(1'b1, 32'h500, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h504, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h508, 1'b1, 1'b0);
        chk("pp_pre_head", out_pc, 32'h500);
        tick();
        drive(1'b1, 32'h50C, 1'b0, 1'b0);
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_head",  out_pc, 32'h504);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1; #1;
        tick();
        rst = 1'b0; #1;
        chk("mid_rst_count",  32'(count), 32'd0);
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'h0);
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid_rst_first_push", out_pc, 32'h600);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the FETCH stage and decode in the BEAN RISC-V core. Accepts one (pc, command) pair per cycle from FETCH over a valid/ready handshake and holds up to DEPTH entries in order. It presents the oldest entry to decode over a second valid/ready handshake. A single-cycle flush discards all held entries on branch/exception redirect, so decode never sees wrong-path instructions.

## Interface
- XPR_LEN, 32: width of pc and command words (matches `XPR_LEN` from BEAN.cfg).
- DEPTH, 4: number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridden).

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries this cycle (redirect from execute).
- in_valid  in  1  FETCH presents a valid entry.
- in_ready  out  1  queue accepts an entry this cycle.
- in_pc  in  XPR_LEN  pc of the fetched instruction.
- in_command  in  XPR_LEN  fetched instruction word.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes the head entry this cycle.
- out_pc  out  XPR_LEN  pc of the head entry.
- out_command  out  XPR_LEN  instruction word of the head entry.
- count  out  PTR_W+1  number of entries held (0..DEPTH).

## Operation
- Storage: DEPTH-entry circular buffer of {pc, command}; write pointer wr_ptr and read pointer rd_ptr (PTR_W bits, wrap modulo DEPTH); occupancy count register (PTR_W+1 bits).
- in_ready = !rst && !flush && (count != DEPTH). Driven combinationally from registered count and flush/rst only; it does not depend on out_ready (no pass-through when full).
- push = in_valid && in_ready: write {in_pc, in_command} at wr_ptr; wr_ptr += 1 (wraps DEPTH-1 -> 0).
- out_valid = (count != 0) && !flush.
- pop = out_valid && out_ready: rd_ptr += 1 (wraps).
- out_pc/out_command = entry at rd_ptr when out_valid, else all zeros.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged. Both are legal whenever 0 < count < DEPTH.
- Empty (count==0): no bypass; a push becomes visible on out_* the following cycle. A pop cannot occur.
- Full (count==DEPTH): in_ready=0, and in_valid is ignored. A pop in that cycle leaves count=DEPTH-1, and in_ready rises next cycle.
- flush: wr_ptr, rd_ptr, count all go to 0 next edge. Any push or pop attempted in the flush cycle has no effect, because in_ready and out_valid are forced low. Storage contents are not cleared.
- rst has priority over flush. It resets wr_ptr=0, rd_ptr=0, count=0. Storage is not reset.
- FETCH must hold in_pc/in_command stable while in_valid && !in_ready. The queue does not check this.

## Timing
- Reset values (cycle after rst sampled high): count=0, out_valid=0, out_pc=0, out_command=0. in_ready=0 while rst is high, and 1 the first cycle after rst deasserts.
- Push-to-output latency: 1 cycle. An entry pushed at edge N is on out_* with out_valid=1 after edge N, if it is the head.
- Throughput: 1 push and 1 pop per cycle sustained with no bubbles when 0<count<DEPTH.
- Flush-to-accept: in the cycle after flush deasserts, in_ready=1 and out_valid=0.
- Reset mid-operation: identical to flush. All entries are lost and the first post-reset push is the next output.
- Order: strict FIFO. Wrap-around of both pointers is transparent to ordering.

## Test plan
- Reset then single push (pc=0x1000, cmd=0x00000013), out_ready=0 -> one cycle later out_valid=1, out_pc=0x1000, out_command=0x00000013, count=1; holds until out_ready=1, then count=0, out_valid=0, out_*=0.
- Fill with DEPTH=4 pushes (pc 0x0,0x4,0x8,0xC), out_ready=0 -> count=4, in_ready=0. A fifth in_valid with pc 0x10 is not accepted. One pop gives out_pc=0x0, then in_ready=1 next cycle, and 0x10 is accepted as the 4th entry.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles, pc incrementing by 4 from 0x2000 -> count stays 1 after the first cycle. out_pc sequence is 0x2000..0x2024 with no gaps and pointers wrap twice.
- Flush with count=3 and simultaneous in_valid=1, out_ready=1 -> in_ready=0 and out_valid=0 in the flush cycle. Next cycle count=0, out_valid=0, in_ready=1. The next push (pc=0x3000) appears first at the output.
- Simultaneous push/pop at count=2 -> count remains 2 and the output order is preserved. rst asserted with count=3 -> next cycle count=0, out_valid=0, out_pc=0.
